prog_ctr: RTL and testbench

PROG_CTR -- requirements
Module: prog_ctr

---
 rtl/prog_ctr_pkg.sv | 16 +
 rtl/prog_ctr_if.sv | 35 +++
 rtl/prog_ctr.sv | 84 ++++++++
 tb/tb_prog_ctr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg -- shared definitions for the program counter block.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   PW_DEF  : default program-counter / Target width
//   CW_DEF  : default run-cycle counter width
package prog_ctr_pkg;

   localparam int PW_DEF = 10;
   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/prog_ctr_if.sv
// prog_ctr_if -- control/status bundle between the instruction decoder
// and the program counter.
//   Start, Stall, Halt, Jump, Branch, Cond, Target : decoder -> counter
//   PC, Busy, Done, Cycles                         : counter -> decoder
// master = decoder side, slave = prog_ctr side.
interface prog_ctr_if
   import prog_ctr_pkg::*;
#(
   parameter int PW = PW_DEF,
   parameter int CW = CW_DEF
);

   logic          Start;
   logic          Stall;
   logic          Halt;
   logic          Jump;
   logic          Branch;
   logic          Cond;
   logic [PW-1:0] Target;
   logic [PW-1:0] PC;
   logic          Busy;
   logic          Done;
   logic [CW-1:0] Cycles;

   modport master (
      output Start, Stall, Halt, Jump, Branch, Cond, Target,
      input  PC, Busy, Done, Cycles
   );

   modport slave (
      input  Start, Stall, Halt, Jump, Branch, Cond, Target,
      output PC, Busy, Done, Cycles
   );

endinterface

// File: rtl/prog_ctr.sv
// prog_ctr -- program counter sequencer (IDLE -> RUN -> DONE).
//   clk   : clock, all state changes on the rising edge
//   Reset : synchronous, active-high; forces IDLE, PC=0, Cycles=0
//   bus   : prog_ctr_if.slave
//             in : Start, Stall, Halt, Jump, Branch, Cond, Target
//             out: PC, Busy (in RUN), Done (in DONE), Cycles (RUN count)
// In RUN the next PC is chosen with priority
//   Stall > Halt > Jump > taken Branch > increment.
// Target is used in the same cycle it is presented, so a redirect costs
// exactly the PC register stage. All outputs come straight from flops.
module prog_ctr
   import prog_ctr_pkg::*;
#(
   parameter int PW = PW_DEF,
   parameter int CW = CW_DEF
) (
   input logic         clk,
   input logic         Reset,
   prog_ctr_if.slave   bus
);

   state_t        state, state_nx;
   logic [PW-1:0] pc, pc_nx;
   logic [CW-1:0] cycles, cycles_nx;
   logic          busy, done;

   // Next state, next PC and next cycle count.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      cycles_nx = cycles;
      case (state)
         IDLE, DONE: begin
            if (bus.Start) begin
               state_nx  = RUN;
               pc_nx     = '0;
               cycles_nx = '0;
            end
         end
         RUN: begin
            // Every RUN cycle counts, stalled or not; hold at all-ones.
            if (cycles != '1)
               cycles_nx = cycles + 1'b1;
            if (!bus.Stall) begin
               if (bus.Halt)
                  state_nx = DONE;                // PC keeps the halt address
               else if (bus.Jump)
                  pc_nx = bus.Target;
               else if (bus.Branch && bus.Cond)
                  pc_nx = pc + bus.Target;        // two's-complement offset, wraps
               else
                  pc_nx = pc + 1'b1;
            end
         end
         default: begin
            state_nx  = IDLE;
            pc_nx     = '0;
            cycles_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state  <= IDLE;
         pc     <= '0;
         cycles <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         cycles <= cycles_nx;
         busy   <= (state_nx == RUN);
         done   <= (state_nx == DONE);
      end
   end

   assign bus.PC     = pc;
   assign bus.Busy   = busy;
   assign bus.Done   = done;
   assign bus.Cycles = cycles;

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr -- directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the program counter.
module tb_prog_ctr;

   localparam int PW = 10;
   localparam int CW = 8;   // narrow so saturation is reachable quickly

   logic clk = 1'b0;
   logic Reset;

   always #5 clk = ~clk;

   prog_ctr_if #(.PW(PW), .CW(CW)) bus ();

   prog_ctr #(.PW(PW), .CW(CW)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: 0 = idle, 1 = running, 2 = finished.
   int          m_st  = 0;
   int unsigned m_pc  = 0;
   int unsigned m_cyc = 0;

   localparam int unsigned PC_MOD  = 1 << PW;
   localparam int unsigned CYC_MAX = (1 << CW) - 1;

   task automatic set_in(input logic st, input logic sl, input logic h,
                         input logic j, input logic b, input logic c,
                         input logic [PW-1:0] t);
      bus.Start = st; bus.Stall = sl; bus.Halt = h;
      bus.Jump = j; bus.Branch = b; bus.Cond = c; bus.Target = t;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (Reset) begin
         m_st = 0; m_pc = 0; m_cyc = 0;
      end else if (m_st != 1) begin
         if (bus.Start) begin
            m_st = 1; m_pc = 0; m_cyc = 0;
         end
      end else begin
         if (m_cyc < CYC_MAX) m_cyc = m_cyc + 1;
         if (!bus.Stall) begin
            if (bus.Halt)                    m_st = 2;
            else if (bus.Jump)               m_pc = bus.Target;
            else if (bus.Branch && bus.Cond) m_pc = (m_pc + bus.Target) % PC_MOD;
            else                             m_pc = (m_pc + 1) % PC_MOD;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      set_in(1, 0, 0, 1, 1, 1, 10'd5);
      tick(); tick();
      n_chk++; if (bus.PC !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.PC); end
      n_chk++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
      n_chk++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.Done); end
      n_chk++; if (bus.Cycles !== 8'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", bus.Cycles); end
   endtask

   // First cycle out of reset with Start high, then five plain RUN cycles.
   task automatic test_run_inc();
      Reset = 1'b0;
      set_in(1, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (bus.PC !== 10'd0 || bus.Busy !== 1'b1 || bus.Cycles !== 8'd0) begin
         n_fail++; $display("FAIL start: got pc=%h busy=%b cyc=%0d want pc=0 busy=1 cyc=0", bus.PC, bus.Busy, bus.Cycles); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_chk++; if (bus.PC !== PW'(i)) begin n_fail++; $display("FAIL inc_pc: got %h want %h", bus.PC, PW'(i)); end
      end
      n_chk++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL inc_busy: got %b want 1", bus.Busy); end
      n_chk++; if (bus.Cycles !== 8'd5) begin n_fail++; $display("FAIL inc_cycles: got %0d want 5", bus.Cycles); end
   endtask

   task automatic test_jump();
      set_in(0, 0, 0, 1, 0, 0, 10'd7); tick();
      n_chk++; if (bus.PC !== 10'd7) begin n_fail++; $display("FAIL jump7: got %h want 007", bus.PC); end
      set_in(0, 0, 0, 1, 0, 0, 10'h155); tick();
      n_chk++; if (bus.PC !== 10'h155) begin n_fail++; $display("FAIL jump155: got %h want 155", bus.PC); end
      set_in(0, 0, 0, 1, 1, 1, 10'd3); tick();
      n_chk++; if (bus.PC !== 10'd3) begin n_fail++; $display("FAIL jump_over_branch: got %h want 003", bus.PC); end
   endtask

   task automatic test_branch();
      set_in(0, 0, 0, 1, 0, 0, 10'd4); tick();
      set_in(0, 0, 0, 0, 1, 1, 10'h3FE); tick();
      n_chk++; if (bus.PC !== 10'd2) begin n_fail++; $display("FAIL branch_taken: got %h want 002", bus.PC); end
      set_in(0, 0, 0, 1, 0, 0, 10'd4); tick();
      set_in(0, 0, 0, 0, 1, 0, 10'h3FE); tick();
      n_chk++; if (bus.PC !== 10'd5) begin n_fail++; $display("FAIL branch_not_taken: got %h want 005", bus.PC); end
      set_in(0, 0, 0, 1, 0, 0, 10'h3FF); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); tick();
      n_chk++; if (bus.PC !== 10'd0) begin n_fail++; $display("FAIL pc_wrap: got %h want 000", bus.PC); end
   endtask

   task automatic test_stall_halt();
      int unsigned c0;
      set_in(0, 0, 0, 1, 0, 0, 10'd9); tick();
      c0 = m_cyc;
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 1, 1, 1, 1, 10'd55); tick();
         n_chk++; if (bus.PC !== 10'd9 || bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: got pc=%h busy=%b done=%b want pc=009 busy=1 done=0", bus.PC, bus.Busy, bus.Done); end
      end
      n_chk++; if (bus.Cycles !== CW'(c0 + 3)) begin n_fail++; $display("FAIL stall_cycles: got %0d want %0d", bus.Cycles, c0 + 3); end
      set_in(0, 0, 1, 0, 0, 0, 0); tick();
      n_chk++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.PC !== 10'd9) begin
         n_fail++; $display("FAIL halt: got done=%b busy=%b pc=%h want done=1 busy=0 pc=009", bus.Done, bus.Busy, bus.PC); end
      set_in(0, 0, 0, 1, 1, 1, 10'd100); tick(); tick();
      n_chk++; if (bus.Done !== 1'b1 || bus.PC !== 10'd9 || bus.Cycles !== CW'(c0 + 4)) begin
         n_fail++; $display("FAIL done_frozen: got done=%b pc=%h cyc=%0d want done=1 pc=009 cyc=%0d", bus.Done, bus.PC, bus.Cycles, c0 + 4); end
   endtask

   task automatic test_restart();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      n_chk++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.PC !== 10'd0 || bus.Cycles !== 8'd0) begin
         n_fail++; $display("FAIL restart: got busy=%b done=%b pc=%h cyc=%0d want 1 0 000 0", bus.Busy, bus.Done, bus.PC, bus.Cycles); end
      set_in(0, 0, 0, 1, 0, 0, 10'd6); tick();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      n_chk++; if (bus.PC !== 10'd7 || bus.Busy !== 1'b1 || bus.Cycles !== 8'd2) begin
         n_fail++; $display("FAIL start_in_run: got pc=%h busy=%b cyc=%0d want pc=007 busy=1 cyc=2", bus.PC, bus.Busy, bus.Cycles); end
   endtask

   task automatic test_reset_mid_run();
      set_in(0, 0, 0, 1, 0, 0, 10'h20); tick();
      Reset = 1'b1;
      set_in(0, 0, 0, 1, 0, 0, 10'h123); tick();
      n_chk++; if (bus.PC !== 10'd0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Cycles !== 8'd0) begin
         n_fail++; $display("FAIL reset_mid_run: got pc=%h busy=%b done=%b cyc=%0d want 000 0 0 0", bus.PC, bus.Busy, bus.Done, bus.Cycles); end
      Reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0); tick();
      n_chk++; if (bus.Busy !== 1'b0 || bus.PC !== 10'd0) begin
         n_fail++; $display("FAIL idle_after_reset: got busy=%b pc=%h want 0 000", bus.Busy, bus.PC); end
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 1, 0, 0, 0, 0); tick();
      Reset = 1'b1;
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      n_chk++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Cycles !== 8'd0) begin
         n_fail++; $display("FAIL reset_in_done: got done=%b busy=%b cyc=%0d want 0 0 0", bus.Done, bus.Busy, bus.Cycles); end
      Reset = 1'b0;
   endtask

   task automatic test_saturation();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 1, 0, 0, 0, 0, 0);
      repeat (260) tick();
      n_chk++; if (bus.Cycles !== 8'hFF || bus.PC !== 10'd0) begin
         n_fail++; $display("FAIL saturate: got cyc=%0d pc=%h want 255 000", bus.Cycles, bus.PC); end
      set_in(0, 0, 1, 0, 0, 0, 0); tick();
      n_chk++; if (bus.Done !== 1'b1 || bus.Cycles !== 8'hFF) begin
         n_fail++; $display("FAIL saturate_halt: got done=%b cyc=%0d want 1 255", bus.Done, bus.Cycles); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         Reset = ($urandom_range(0, 39) == 0);
         set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, 1'($urandom),
                PW'($urandom));
         tick();
         n_chk++;
         if (bus.PC !== PW'(m_pc) || bus.Cycles !== CW'(m_cyc) ||
             bus.Busy !== (m_st == 1) || bus.Done !== (m_st == 2)) begin
            n_fail++;
            $display("FAIL random[%0d]: got pc=%h cyc=%0d busy=%b done=%b want pc=%h cyc=%0d busy=%b done=%b",
                     i, bus.PC, bus.Cycles, bus.Busy, bus.Done, PW'(m_pc), m_cyc, m_st == 1, m_st == 2);
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_run_inc();
      test_jump();
      test_branch();
      test_stall_halt();
      test_restart();
      test_reset_mid_run();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
